// File: rtl/fifo_put_arbiter.sv
// fifo_put_arbiter: round-robin arbiter that shares the FIFO put port among
// N_REQ producers. It grants bursts of up to MAX_BURST words and drives a
// registered en_put/data_put pair that holds its word while the FIFO is full.
module fifo_put_arbiter #(
  parameter int unsigned N_BITS    = 32,
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      init,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*N_BITS-1:0]   data_in,
  output logic [N_REQ-1:0]          ack,
  input  logic                      full,
  output logic                      en_put,
  output logic [N_BITS-1:0]         data_put,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy
);

  localparam int unsigned ID_W  = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [N_REQ-1:0]   req_sh;
  logic               req_owner;
  logic               keep_owner;
  logic [ID_W-1:0]    rr_base;
  logic [ID_W:0]      rr_res;
  logic               win_valid;
  logic [ID_W-1:0]    win_id;
  logic               can_load;
  logic               xfer;
  logic [N_BITS-1:0]  win_word;
  logic [CNT_W-1:0]   new_cnt;

  // Successor of a requester index, wrapping at N_REQ (need not be a power of two).
  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    if (32'(id) >= N_REQ - 1) return '0;
    return id + ID_W'(1);
  endfunction

  // First set request at or after base, searching upward with wrap; MSB flags a hit.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [ID_W-1:0]  base);
    logic             found;
    logic [ID_W-1:0]  pick;
    logic [N_REQ-1:0] rsh;
    int unsigned      idx;
    found = 1'b0;
    pick  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(base) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      rsh = r >> idx;
      if (!found && rsh[0]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
    return {found, pick};
  endfunction

  // Winner selection: the owner keeps the grant while it requests; otherwise
  // re-arbitrate from the slot after the owner (BURST) or from ptr (IDLE).
  always_comb begin
    req_sh     = req >> owner_q;
    req_owner  = req_sh[0];
    keep_owner = (state_q == S_BURST) && req_owner;
    rr_base    = (state_q == S_BURST) ? next_id(owner_q) : ptr_q;
    rr_res     = rr_pick(req, rr_base);
    if (keep_owner) begin
      win_valid = 1'b1;
      win_id    = owner_q;
    end else begin
      win_valid = rr_res[ID_W];
      win_id    = rr_res[ID_W-1:0];
    end
    can_load = !en_put || !full;
    xfer     = win_valid && can_load && !init;
    win_word = N_BITS'(data_in >> (32'(win_id) * N_BITS));
  end

  // State register: burst owner, word count and round-robin pointer.
  always_ff @(posedge clk) begin
    if (init) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state: count transfers, close the burst at the limit or on owner drop.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    new_cnt = keep_owner ? cnt_q + CNT_W'(1) : CNT_W'(1);
    if (xfer) begin
      owner_d = win_id;
      // Owner dropped and a new one took over in the same cycle.
      if (!keep_owner && (state_q == S_BURST)) ptr_d = next_id(owner_q);
      if (new_cnt == CNT_W'(MAX_BURST)) begin
        ptr_d   = next_id(win_id);
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        state_d = S_BURST;
        cnt_d   = new_cnt;
      end
    end else if ((state_q == S_BURST) && !req_owner && can_load) begin
      // Owner dropped and nobody else is asking.
      ptr_d   = next_id(owner_q);
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // Outputs decoded from state: one-hot ack, owner id and busy flag.
  always_comb begin
    ack      = '0;
    busy     = (state_q == S_BURST);
    grant_id = '0;
    if (xfer) ack = N_REQ'(1) << win_id;
    if (state_q == S_BURST) grant_id = owner_q;
  end

  // Put register: load on transfer, drop when the word leaves, hold while full.
  always_ff @(posedge clk) begin
    if (init) begin
      en_put   <= 1'b0;
      data_put <= '0;
    end else if (xfer) begin
      en_put   <= 1'b1;
      data_put <= win_word;
    end else if (!full) begin
      en_put   <= 1'b0;
    end
  end

endmodule
